// File: rtl/multicycle_core.sv
// Multi-cycle datapath core: register file, sign extender, ALU and data memory,
// stepped through READ, EXEC, optional MEM and WB by a single state machine.
module multicycle_core #(
    parameter int WIDTH       = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_ADDR_W  = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [15:0]           immediate,
    input  logic [WIDTH-1:0]      new_PC,
    input  logic [1:0]            regdst,
    input  logic [2:0]            alu_ctrl,
    input  logic                  alu_src,
    input  logic                  mem_wr,
    input  logic                  reg_wr,
    input  logic [1:0]            mem_to_reg,
    output logic [WIDTH-1:0]      Da,
    output logic                  is_zero,
    output logic                  overflow,
    output logic                  done
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, READ, EXEC, MEM, WB} state_t;

    state_t                  state;
    logic [REG_ADDR_W-1:0]   rd_q, rt_q, rs_q;
    logic [15:0]             imm_q;
    logic [WIDTH-1:0]        pc_q;
    logic [1:0]              regdst_q, mem_to_reg_q;
    logic [2:0]              alu_ctrl_q;
    logic                    alu_src_q, mem_wr_q, reg_wr_q;
    logic [WIDTH-1:0]        a_q, b_q, alu_out, mdr;
    logic [CNT_W-1:0]        cnt;
    logic [WIDTH-1:0]        regs [2**REG_ADDR_W];
    logic [WIDTH-1:0]        mem  [2**MEM_ADDR_W];

    logic [WIDTH-1:0]        imm_ext, op_b, sum, diff, alu_res;
    logic                    alu_ovf, is_load, wb_en;
    logic [MEM_ADDR_W-1:0]   mem_addr;
    logic [REG_ADDR_W-1:0]   wb_addr;
    logic [WIDTH-1:0]        wb_data;

    assign imm_ext  = WIDTH'($signed(imm_q));
    assign op_b     = alu_src_q ? imm_ext : b_q;
    assign sum      = a_q + op_b;
    assign diff     = a_q - op_b;
    assign is_load  = (mem_to_reg_q == 2'b01);
    assign mem_addr = alu_out[MEM_ADDR_W-1:0];
    assign Da       = a_q;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (alu_ctrl_q)
            3'b000: begin
                alu_res = sum;
                alu_ovf = (a_q[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: begin
                alu_res = diff;
                alu_ovf = (a_q[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b010: alu_res = a_q ^ op_b;
            3'b011: alu_res[0] = ($signed(a_q) < $signed(op_b));
            3'b100: alu_res = a_q & op_b;
            3'b101: alu_res = ~(a_q & op_b);
            3'b110: alu_res = ~(a_q | op_b);
            default: alu_res = a_q | op_b;
        endcase
    end

    always_comb begin
        wb_addr = rd_q;
        wb_data = alu_out;
        unique case (regdst_q)
            2'b01:   wb_addr = rt_q;
            2'b10:   wb_addr = '1;
            default: wb_addr = rd_q;
        endcase
        unique case (mem_to_reg_q)
            2'b01:   wb_data = mdr;
            2'b10:   wb_data = pc_q;
            default: wb_data = alu_out;
        endcase
        wb_en = reg_wr_q && (regdst_q != 2'b11) && (mem_to_reg_q != 2'b11) && (wb_addr != '0);
    end

    // Store happens once, on the first MEM cycle; a combined store+load then reads it back.
    always_ff @(posedge clk) begin
        if (!reset && state == MEM && mem_wr_q && cnt == '0)
            mem[mem_addr] <= b_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            instr_ready  <= 1'b1;
            done         <= 1'b0;
            rd_q         <= '0;
            rt_q         <= '0;
            rs_q         <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            regdst_q     <= '0;
            mem_to_reg_q <= '0;
            alu_ctrl_q   <= '0;
            alu_src_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            reg_wr_q     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            alu_out      <= '0;
            mdr          <= '0;
            cnt          <= '0;
            is_zero      <= 1'b0;
            overflow     <= 1'b0;
            for (int i = 0; i < 2**REG_ADDR_W; i++)
                regs[i] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (instr_valid) begin
                    rd_q         <= rd;
                    rt_q         <= rt;
                    rs_q         <= rs;
                    imm_q        <= immediate;
                    pc_q         <= new_PC;
                    regdst_q     <= regdst;
                    mem_to_reg_q <= mem_to_reg;
                    alu_ctrl_q   <= alu_ctrl;
                    alu_src_q    <= alu_src;
                    mem_wr_q     <= mem_wr;
                    reg_wr_q     <= reg_wr;
                    instr_ready  <= 1'b0;
                    state        <= READ;
                end
                READ: begin
                    a_q   <= regs[rs_q];
                    b_q   <= regs[rt_q];
                    state <= EXEC;
                end
                EXEC: begin
                    alu_out  <= alu_res;
                    is_zero  <= (alu_res == '0);
                    overflow <= alu_ovf;
                    cnt      <= '0;
                    if (mem_wr_q || is_load) begin
                        state <= MEM;
                    end else begin
                        state <= WB;
                        done  <= 1'b1;
                    end
                end
                MEM: begin
                    if (!is_load || cnt == LAST_CNT) begin
                        if (is_load)
                            mdr <= mem_wr_q ? b_q : mem[mem_addr];
                        state <= WB;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WB: begin
                    if (wb_en)
                        regs[wb_addr] <= wb_data;
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed self-checking bench for multicycle_core (WIDTH=32, MEM_LATENCY=3).
module tb_multicycle_core;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, SLT = 3'b011;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  rd, rt, rs;
    logic [15:0] immediate;
    logic [31:0] new_PC;
    logic [1:0]  regdst, mem_to_reg;
    logic [2:0]  alu_ctrl;
    logic        alu_src, mem_wr, reg_wr;
    logic [31:0] Da;
    logic        is_zero, overflow, done;

    int checks = 0;
    int passes = 0;

    multicycle_core #(.WIDTH(32), .REG_ADDR_W(5), .MEM_ADDR_W(10), .MEM_LATENCY(3)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rd(rd), .rt(rt), .rs(rs), .immediate(immediate), .new_PC(new_PC),
        .regdst(regdst), .alu_ctrl(alu_ctrl), .alu_src(alu_src), .mem_wr(mem_wr),
        .reg_wr(reg_wr), .mem_to_reg(mem_to_reg), .Da(Da), .is_zero(is_zero),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] t_rd, input logic [4:0] t_rt, input logic [4:0] t_rs,
                         input logic [15:0] t_imm, input logic [31:0] t_pc, input logic [1:0] t_regdst,
                         input logic [2:0] t_alu, input logic t_src, input logic t_mw, input logic t_rw,
                         input logic [1:0] t_m2r);
        rd = t_rd; rt = t_rt; rs = t_rs; immediate = t_imm; new_PC = t_pc;
        regdst = t_regdst; alu_ctrl = t_alu; alu_src = t_src; mem_wr = t_mw;
        reg_wr = t_rw; mem_to_reg = t_m2r;
    endtask

    // Holds valid through one accept edge; returns just after that edge.
    task automatic accept();
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    // lat = number of cycles after the accept cycle at which done is seen; 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic issue(input logic [4:0] t_rd, input logic [4:0] t_rt, input logic [4:0] t_rs,
                         input logic [15:0] t_imm, input logic [31:0] t_pc, input logic [1:0] t_regdst,
                         input logic [2:0] t_alu, input logic t_src, input logic t_mw, input logic t_rw,
                         input logic [1:0] t_m2r, output int lat);
        @(negedge clk);
        drive(t_rd, t_rt, t_rs, t_imm, t_pc, t_regdst, t_alu, t_src, t_mw, t_rw, t_m2r);
        accept();
        wait_done(lat);
    endtask

    task automatic addi(input logic [4:0] r, input logic [15:0] imm);
        int lat;
        issue(r, 5'd0, 5'd0, imm, 32'h0, 2'b00, ADD, 1'b1, 1'b0, 1'b1, 2'b00, lat);
    endtask

    task automatic link(input logic [4:0] r, input logic [31:0] val);
        int lat;
        issue(r, 5'd0, 5'd0, 16'h0, val, 2'b00, ADD, 1'b0, 1'b0, 1'b1, 2'b10, lat);
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] val);
        int lat;
        issue(5'd0, 5'd0, r, 16'h0, 32'h0, 2'b11, ADD, 1'b0, 1'b0, 1'b0, 2'b11, lat);
        val = Da;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr_valid = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 2'b00, ADD, 1'b0, 1'b0, 1'b0, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", instr_ready); else passes++;
        checks++; if (Da !== 32'h0) $display("[TB] FAIL reset_Da got %h want 0", Da); else passes++;
        checks++; if (is_zero !== 1'b0) $display("[TB] FAIL reset_is_zero got %b want 0", is_zero); else passes++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow got %b want 0", overflow); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else passes++;
        reset = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        logic [31:0] v;
        addi(5'd1, 16'd5);
        addi(5'd2, 16'd7);
        issue(5'd3, 5'd2, 5'd1, 16'h0, 32'h0, 2'b00, ADD, 1'b0, 1'b0, 1'b1, 2'b00, lat);
        checks++; if (lat !== 3) $display("[TB] FAIL add_latency got %0d want 3", lat); else passes++;
        checks++; if (Da !== 32'd5) $display("[TB] FAIL add_Da got %h want 5", Da); else passes++;
        checks++; if (is_zero !== 1'b0) $display("[TB] FAIL add_is_zero got %b want 0", is_zero); else passes++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL add_overflow got %b want 0", overflow); else passes++;
        read_reg(5'd3, v);
        checks++; if (v !== 32'd12) $display("[TB] FAIL add_R3 got %h want c", v); else passes++;
        addi(5'd15, 16'hFFFF);
        read_reg(5'd15, v);
        checks++; if (v !== 32'hFFFFFFFF) $display("[TB] FAIL sext_R15 got %h want ffffffff", v); else passes++;
    endtask

    task automatic test_alu_ops();
        int lat;
        logic [31:0] v;
        logic [31:0] exp_tab [7];
        // R1=5, R2=7; entries for SUB, XOR, SLT, AND, NAND, NOR, OR
        exp_tab = '{32'hFFFFFFFE, 32'h2, 32'h1, 32'h5, 32'hFFFFFFFA, 32'hFFFFFFF8, 32'h7};
        for (int k = 0; k < 7; k++) begin
            issue(5'd8, 5'd2, 5'd1, 16'h0, 32'h0, 2'b00, 3'(k + 1), 1'b0, 1'b0, 1'b1, 2'b00, lat);
            read_reg(5'd8, v);
            checks++; if (v !== exp_tab[k]) $display("[TB] FAIL alu_op%0d got %h want %h", k + 1, v, exp_tab[k]); else passes++;
        end
    endtask

    task automatic test_sub();
        int lat;
        logic [31:0] v;
        link(5'd6, 32'h7FFFFFFF);
        link(5'd5, 32'hFFFFFFFF);
        issue(5'd7, 5'd5, 5'd6, 16'h0, 32'h0, 2'b00, SUB, 1'b0, 1'b0, 1'b1, 2'b00, lat);
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL sub_overflow got %b want 1", overflow); else passes++;
        checks++; if (is_zero !== 1'b0) $display("[TB] FAIL sub_is_zero got %b want 0", is_zero); else passes++;
        read_reg(5'd7, v);
        checks++; if (v !== 32'h80000000) $display("[TB] FAIL sub_R7 got %h want 80000000", v); else passes++;
        issue(5'd9, 5'd1, 5'd1, 16'h0, 32'h0, 2'b00, SUB, 1'b0, 1'b0, 1'b1, 2'b00, lat);
        checks++; if (is_zero !== 1'b1) $display("[TB] FAIL subself_is_zero got %b want 1", is_zero); else passes++;
        checks++; if (overflow !== 1'b0) $display("[TB] FAIL subself_overflow got %b want 0", overflow); else passes++;
        read_reg(5'd9, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL subself_R9 got %h want 0", v); else passes++;
        issue(5'd10, 5'd1, 5'd5, 16'h0, 32'h0, 2'b00, SLT, 1'b0, 1'b0, 1'b1, 2'b00, lat);
        read_reg(5'd10, v);
        checks++; if (v !== 32'h1) $display("[TB] FAIL slt_neg_lt_pos got %h want 1", v); else passes++;
        issue(5'd10, 5'd5, 5'd1, 16'h0, 32'h0, 2'b00, SLT, 1'b0, 1'b0, 1'b1, 2'b00, lat);
        read_reg(5'd10, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL slt_pos_lt_neg got %h want 0", v); else passes++;
        issue(5'd0, 5'd0, 5'd6, 16'd1, 32'h0, 2'b00, ADD, 1'b1, 1'b0, 1'b1, 2'b00, lat);
        checks++; if (overflow !== 1'b1) $display("[TB] FAIL add_overflow got %b want 1", overflow); else passes++;
    endtask

    task automatic test_mem();
        int lat;
        logic [31:0] v;
        link(5'd2, 32'hDEADBEEF);
        issue(5'd0, 5'd2, 5'd0, 16'd4, 32'h0, 2'b11, ADD, 1'b1, 1'b1, 1'b0, 2'b00, lat);
        checks++; if (lat !== 4) $display("[TB] FAIL store_latency got %0d want 4", lat); else passes++;
        issue(5'd0, 5'd4, 5'd0, 16'd4, 32'h0, 2'b01, ADD, 1'b1, 1'b0, 1'b1, 2'b01, lat);
        checks++; if (lat !== 6) $display("[TB] FAIL load_latency got %0d want 6", lat); else passes++;
        read_reg(5'd4, v);
        checks++; if (v !== 32'hDEADBEEF) $display("[TB] FAIL load_R4 got %h want deadbeef", v); else passes++;
        issue(5'd0, 5'd10, 5'd0, 16'd1028, 32'h0, 2'b01, ADD, 1'b1, 1'b0, 1'b1, 2'b01, lat);
        read_reg(5'd10, v);
        checks++; if (v !== 32'hDEADBEEF) $display("[TB] FAIL load_wrap got %h want deadbeef", v); else passes++;
        issue(5'd11, 5'd1, 5'd0, 16'd8, 32'h0, 2'b00, ADD, 1'b1, 1'b1, 1'b1, 2'b01, lat);
        checks++; if (lat !== 6) $display("[TB] FAIL storeload_latency got %0d want 6", lat); else passes++;
        read_reg(5'd11, v);
        checks++; if (v !== 32'd5) $display("[TB] FAIL storeload_R11 got %h want 5", v); else passes++;
    endtask

    task automatic test_link();
        int lat;
        logic [31:0] v;
        issue(5'd0, 5'd0, 5'd0, 16'h0, 32'h100, 2'b10, ADD, 1'b0, 1'b0, 1'b1, 2'b10, lat);
        read_reg(5'd31, v);
        checks++; if (v !== 32'h100) $display("[TB] FAIL link_R31 got %h want 100", v); else passes++;
        link(5'd0, 32'h55);
        read_reg(5'd0, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL r0_write got %h want 0", v); else passes++;
        issue(5'd31, 5'd0, 5'd0, 16'h0, 32'h77, 2'b11, ADD, 1'b0, 1'b0, 1'b1, 2'b10, lat);
        issue(5'd0, 5'd0, 5'd0, 16'h0, 32'h88, 2'b10, ADD, 1'b0, 1'b0, 1'b1, 2'b11, lat);
        issue(5'd0, 5'd0, 5'd0, 16'h0, 32'h99, 2'b10, ADD, 1'b0, 1'b0, 1'b0, 2'b10, lat);
        read_reg(5'd31, v);
        checks++; if (v !== 32'h100) $display("[TB] FAIL suppress_R31 got %h want 100", v); else passes++;
    endtask

    task automatic test_reset_mid();
        int pulses;
        logic [31:0] v;
        @(negedge clk);
        drive(5'd0, 5'd1, 5'd0, 16'd4, 32'h0, 2'b11, ADD, 1'b1, 1'b1, 1'b0, 2'b00);
        accept();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (instr_ready !== 1'b1) $display("[TB] FAIL midreset_ready got %b want 1", instr_ready); else passes++;
        checks++; if (Da !== 32'h0) $display("[TB] FAIL midreset_Da got %h want 0", Da); else passes++;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses !== 0) $display("[TB] FAIL midreset_done got %0d pulses want 0", pulses); else passes++;
        addi(5'd1, 16'd0);
        issue(5'd0, 5'd12, 5'd0, 16'd4, 32'h0, 2'b01, ADD, 1'b1, 1'b0, 1'b1, 2'b01, pulses);
        read_reg(5'd12, v);
        checks++; if (v !== 32'hDEADBEEF) $display("[TB] FAIL midreset_mem got %h want deadbeef", v); else passes++;
    endtask

    task automatic test_back_to_back();
        int readies, dones;
        logic [31:0] v;
        readies = 0;
        dones = 0;
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (instr_ready) begin
                readies++;
                drive(5'd13, 5'd0, 5'd13, 16'd1, 32'h0, 2'b00, ADD, 1'b1, 1'b0, 1'b1, 2'b00);
            end else begin
                drive(5'd14, 5'd14, 5'd14, 16'd100, 32'h0, 2'b00, ADD, 1'b1, 1'b0, 1'b1, 2'b00);
            end
        end
        instr_valid = 1'b0;
        checks++; if (readies !== 3) $display("[TB] FAIL b2b_ready_cycles got %0d want 3", readies); else passes++;
        checks++; if (dones !== 3) $display("[TB] FAIL b2b_done_pulses got %0d want 3", dones); else passes++;
        read_reg(5'd13, v);
        checks++; if (v !== 32'd3) $display("[TB] FAIL b2b_R13 got %h want 3", v); else passes++;
        read_reg(5'd14, v);
        checks++; if (v !== 32'd0) $display("[TB] FAIL b2b_R14 got %h want 0", v); else passes++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_sub();
        test_mem();
        test_link();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath core.
- Contains the register file, sign extender, ALU and data memory, sequenced by a state machine.
- Accepts one decoded instruction per valid/ready handshake from the control unit, then steps it through READ, EXEC, optional MEM and WB.
- Memory read latency, data width and register/memory depth are configurable.

Parameters:
WIDTH, 32, datapath width (bits); must be >= 16.
REG_ADDR_W, 5, register address width; register file holds 2**REG_ADDR_W entries.
MEM_ADDR_W, 10, data memory word-address width; memory holds 2**MEM_ADDR_W words of WIDTH bits.
MEM_LATENCY, 1, cycles spent in MEM for a load; must be >= 1.

Ports:
clk  in  1  single clock; all state updates on rising edge.
reset  in  1  synchronous, active-high.
instr_valid  in  1  control unit presents an instruction.
instr_ready  out  1  core can accept; high only in IDLE.
rd  in  REG_ADDR_W  destination register field.
rt  in  REG_ADDR_W  second source / alternate destination.
rs  in  REG_ADDR_W  first source.
immediate  in  16  immediate, sign-extended to WIDTH.
new_PC  in  WIDTH  link value for writeback.
regdst  in  2  write address: 00 rd, 01 rt, 10 all-ones (link), 11 suppress write.
alu_ctrl  in  3  000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
alu_src  in  1  0: operand B = R[rt]; 1: operand B = sign-extended immediate.
mem_wr  in  1  store R[rt] to memory.
reg_wr  in  1  register writeback enable.
mem_to_reg  in  2  writeback data: 00 ALU, 01 memory, 10 new_PC, 11 suppress write.
Da  out  WIDTH  registered R[rs] of the current instruction.
is_zero  out  1  registered: ALU result == 0.
overflow  out  1  registered signed overflow; ADD/SUB only, else 0.
done  out  1  one-cycle pulse in WB.

Behaviour:
- States: IDLE, READ, EXEC, MEM, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch every control/field input into internal registers and go to READ.
  - Inputs are ignored outside the accept cycle.
- READ: register A<=R[rs] (also drives Da), B<=R[rt]. Go to EXEC.
- EXEC:
  - ALUout <= A op (alu_src ? sext(imm) : B). Update is_zero and overflow.
  - SLT is a signed compare; the result is 1 or 0, zero-extended.
  - Next state is MEM if mem_wr or mem_to_reg==01, else WB.
- MEM:
  - Word address = ALUout[MEM_ADDR_W-1:0]; upper bits are ignored, so addresses wrap.
  - Store: memory written with B on the edge leaving MEM. MEM lasts exactly 1 cycle.
  - Load: a counter runs 0..MEM_LATENCY-1. On the last cycle, MDR <= mem[addr]; then go to WB.
  - mem_wr together with mem_to_reg==01: write first, then read back the new value. MEM lasts MEM_LATENCY cycles.
- WB:
  - done=1.
  - If reg_wr, regdst!=11 and mem_to_reg!=11, write the selected data to the selected address on the edge leaving WB.
  - Writes to register 0 are discarded; R[0] always reads 0.
  - Go to IDLE.
- Latency, with accept on edge E:
  - done is high in cycle E+3 for non-memory instructions.
  - done is high in cycle E+3+MEM_LATENCY for loads, and E+4 for stores.
  - instr_ready returns the following cycle.
  - Throughput is one instruction per 4 (or 4+MEM) cycles.
- No hazards exist: instructions are strictly sequential, and a write in WB is visible to the next instruction's READ.
- Reset:
  - Outputs: state=IDLE, instr_ready=1 after the reset cycle, Da=0, is_zero=0, overflow=0, done=0.
  - All registers and the counter are cleared, and every register-file entry is set to 0.
  - Memory contents are not reset.
- Reset mid-operation: the instruction is abandoned; no register-file or memory write occurs on the reset edge. Reset dominates instr_valid.

Test Plan:
- Reset, then ADD with rs=1 (R1=5), rt=2 (R2=7), regdst=00, rd=3, reg_wr=1 -> done at accept+3; R3=12, Da=5, is_zero=0, overflow=0.
- SUB 0x7FFFFFFF - 0xFFFFFFFF (WIDTH=32) -> overflow=1. SUB R1-R1 -> is_zero=1, result 0.
- Store R2=0xDEADBEEF to imm 4 (alu_src=1, ADD, rs=0), then load to rt=4 with MEM_LATENCY=3 -> store done at accept+4; load done at accept+6; R4=0xDEADBEEF.
- regdst=10, mem_to_reg=10, new_PC=0x100, reg_wr=1 -> R31=0x100. Repeat with rd=0 and regdst=00 -> R0 still reads 0.
- Assert reset during MEM of a store -> memory word unchanged, state IDLE, done never pulses, instr_ready=1 the cycle after reset.
- Hold instr_valid high for back-to-back instructions -> exactly one accept per IDLE visit, instr_ready low in READ..WB, fields changed mid-instruction are ignored.
